// File: rtl/issue_arbiter.sv
// Issue arbiter for the int / load-store / multiply / divide queues: grants at most one
// issue per cycle so that no two results ever reach the common data bus in the same cycle.
module issue_arbiter #(
   parameter int INT_LAT  = 1,
   parameter int LS_LAT   = 2,
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 7,
   parameter int MAX_LAT  = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       int_ready,
   input  logic       ls_ready,
   input  logic       mult_ready,
   input  logic       div_ready,
   output logic       int_issue,
   output logic       ls_issue,
   output logic       mult_issue,
   output logic       div_issue,
   output logic [3:0] cdb_sel,
   output logic       div_busy
);

   localparam int CW = $clog2(MAX_LAT + 1);
   localparam logic [1:0] ID_INT  = 2'd0;
   localparam logic [1:0] ID_LS   = 2'd1;
   localparam logic [1:0] ID_MULT = 2'd2;
   localparam logic [1:0] ID_DIV  = 2'd3;

   // Handshake: *_ready is a level from the queue; *_issue is combinational in the same
   // cycle and the queue pops on the next rising edge. No memory is kept of denied requests.

   // Slot 0 is not stored here: the registered cdb_sel is the slot-0 contents.
   logic [MAX_LAT:1]      resv;
   logic [MAX_LAT:1][1:0] own;
   logic [MAX_LAT:0]      resv_nxt;
   logic [MAX_LAT:0][1:0] own_nxt;
   logic [CW-1:0]         div_cnt;
   logic                  lru;   // 0: int wins an int/ls tie, 1: ls wins

   logic elig_int, elig_ls, elig_mult, elig_div;
   logic low_ok;
   logic gnt_int, gnt_ls, gnt_mult, gnt_div;

   assign div_busy = (div_cnt != '0);

   always_comb begin
      elig_int  = int_ready  & ~resv[INT_LAT];
      elig_ls   = ls_ready   & ~resv[LS_LAT];
      elig_mult = mult_ready & ~resv[MULT_LAT];
      elig_div  = div_ready  & ~resv[DIV_LAT] & ~div_busy;
      low_ok    = ~elig_div & ~elig_mult;
      gnt_div   = rst & elig_div;
      gnt_mult  = rst & elig_mult & ~elig_div;
      gnt_int   = rst & low_ok & elig_int & (~elig_ls | ~lru);
      gnt_ls    = rst & low_ok & elig_ls  & (~elig_int | lru);
   end

   assign int_issue  = gnt_int;
   assign ls_issue   = gnt_ls;
   assign mult_issue = gnt_mult;
   assign div_issue  = gnt_div;

   // Shift the reservation window by one and drop the new claim at slot L-1.
   always_comb begin
      resv_nxt = '0;
      own_nxt  = '0;
      for (int j = 0; j < MAX_LAT; j++) begin
         resv_nxt[j] = resv[j+1];
         own_nxt[j]  = own[j+1];
         if (gnt_int && (j + 1 == INT_LAT)) begin
            resv_nxt[j] = 1'b1;
            own_nxt[j]  = ID_INT;
         end
         if (gnt_ls && (j + 1 == LS_LAT)) begin
            resv_nxt[j] = 1'b1;
            own_nxt[j]  = ID_LS;
         end
         if (gnt_mult && (j + 1 == MULT_LAT)) begin
            resv_nxt[j] = 1'b1;
            own_nxt[j]  = ID_MULT;
         end
         if (gnt_div && (j + 1 == DIV_LAT)) begin
            resv_nxt[j] = 1'b1;
            own_nxt[j]  = ID_DIV;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resv    <= '0;
         own     <= '0;
         cdb_sel <= 4'b0000;
         div_cnt <= '0;
         lru     <= 1'b0;
      end else begin
         resv    <= resv_nxt[MAX_LAT:1];
         own     <= own_nxt[MAX_LAT:1];
         cdb_sel <= resv_nxt[0] ? (4'b0001 << own_nxt[0]) : 4'b0000;
         if (gnt_int)
            lru <= 1'b1;
         else if (gnt_ls)
            lru <= 1'b0;
         if (gnt_div)
            div_cnt <= CW'(DIV_LAT - 1);
         else if (div_cnt != '0)
            div_cnt <= div_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_issue_arbiter.sv
// Bench for issue_arbiter: directed scenarios plus random ready traffic checked against a
// calendar-based model (absolute-cycle CDB bookings and a divider free time).
module tb_issue_arbiter;

  localparam int INT_LAT  = 1;
  localparam int LS_LAT   = 2;
  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 7;
  localparam int MAX_LAT  = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       int_ready = 1'b0, ls_ready = 1'b0, mult_ready = 1'b0, div_ready = 1'b0;
  logic       int_issue, ls_issue, mult_issue, div_issue;
  logic [3:0] cdb_sel;
  logic       div_busy;
  logic [3:0] issue_vec;

  assign issue_vec = {div_issue, mult_issue, ls_issue, int_issue};

  issue_arbiter #(
    .INT_LAT (INT_LAT),
    .LS_LAT  (LS_LAT),
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT),
    .MAX_LAT (MAX_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .int_ready (int_ready),
    .ls_ready  (ls_ready),
    .mult_ready(mult_ready),
    .div_ready (div_ready),
    .int_issue (int_issue),
    .ls_issue  (ls_issue),
    .mult_issue(mult_issue),
    .div_issue (div_issue),
    .cdb_sel   (cdb_sel),
    .div_busy  (div_busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] r);
    @(posedge clk);
    #1;
    {div_ready, mult_ready, ls_ready, int_ready} = r;
  endtask

  task automatic cyc_chk(input logic [3:0] r, input logic [3:0] exp_iss, input string name);
    step(r);
    @(negedge clk);
    check(name, issue_vec, exp_iss);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    {div_ready, mult_ready, ls_ready, int_ready} = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- scoreboard / reference model ----------------
  // exp_q entries: {absolute cycle the result is on the CDB, expected one-hot select}
  logic [35:0] exp_q[$];
  bit          booked[int];
  int          div_free_at = 0;
  bit          ls_wins_tie = 1'b0;

  int          m_t;
  logic [3:0]  m_sel;
  logic [3:0]  m_gnt;
  bit          e_int, e_ls, e_mult, e_div;

  task automatic book(input int at, input logic [3:0] sel);
    booked[at] = 1'b1;
    exp_q.push_back({at[31:0], sel});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_issue", issue_vec, 4'b0000);
      check("rst_cdb_sel", cdb_sel, 4'b0000);
      check("rst_div_busy", {3'b000, div_busy}, 4'b0000);
      exp_q.delete();
      booked.delete();
      div_free_at = 0;
      ls_wins_tie = 1'b0;
    end else begin
      m_t   = cyc;
      m_sel = 4'b0000;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i][35:4] == m_t[31:0]) begin
          m_sel = exp_q[i][3:0];
          exp_q.delete(i);
          break;
        end
      end
      check("cdb_sel", cdb_sel, m_sel);
      check("div_busy", {3'b000, div_busy}, {3'b000, (m_t < div_free_at)});

      e_div  = div_ready  && !booked.exists(m_t + DIV_LAT) && (m_t >= div_free_at);
      e_mult = mult_ready && !booked.exists(m_t + MULT_LAT);
      e_int  = int_ready  && !booked.exists(m_t + INT_LAT);
      e_ls   = ls_ready   && !booked.exists(m_t + LS_LAT);
      m_gnt  = 4'b0000;
      if (e_div)                       m_gnt = 4'b1000;
      else if (e_mult)                 m_gnt = 4'b0100;
      else if (e_int && e_ls)          m_gnt = ls_wins_tie ? 4'b0010 : 4'b0001;
      else if (e_int)                  m_gnt = 4'b0001;
      else if (e_ls)                   m_gnt = 4'b0010;
      check("issue", issue_vec, m_gnt);

      case (m_gnt)
        4'b1000: begin book(m_t + DIV_LAT, 4'b1000); div_free_at = m_t + DIV_LAT; end
        4'b0100: book(m_t + MULT_LAT, 4'b0100);
        4'b0010: begin book(m_t + LS_LAT, 4'b0010); ls_wins_tie = 1'b0; end
        4'b0001: begin book(m_t + INT_LAT, 4'b0001); ls_wins_tie = 1'b1; end
        default: ;
      endcase
      if (booked.exists(m_t)) booked.delete(m_t);
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] r;

  initial begin
    do_reset();

    // int held: one grant per cycle, one int result per cycle
    cyc_chk(4'b0001, 4'b0001, "int_stream_t0");
    cyc_chk(4'b0001, 4'b0001, "int_stream_t1");
    check("int_stream_cdb_t1", cdb_sel, 4'b0001);
    cyc_chk(4'b0001, 4'b0001, "int_stream_t2");
    check("int_stream_cdb_t2", cdb_sel, 4'b0001);

    // mult at t0 blocks an int request at t3 (same CDB slot)
    do_reset();
    cyc_chk(4'b0100, 4'b0100, "mult_t0");
    cyc_chk(4'b0000, 4'b0000, "idle_t1");
    cyc_chk(4'b0000, 4'b0000, "idle_t2");
    cyc_chk(4'b0001, 4'b0000, "int_denied_t3");
    cyc_chk(4'b0001, 4'b0001, "int_retry_t4");
    check("cdb_mult_t4", cdb_sel, 4'b0100);
    cyc_chk(4'b0000, 4'b0000, "idle_t5");
    check("cdb_int_t5", cdb_sel, 4'b0001);

    // div beats mult, divider busy window, earliest next div
    do_reset();
    cyc_chk(4'b1100, 4'b1000, "div_t0");
    cyc_chk(4'b0100, 4'b0100, "mult_t1");
    check("div_busy_t1", {3'b000, div_busy}, 4'b0001);
    repeat (3) cyc_chk(4'b0000, 4'b0000, "idle_t2_t4");
    cyc_chk(4'b0000, 4'b0000, "idle_t5");
    check("cdb_mult_t5", cdb_sel, 4'b0100);
    cyc_chk(4'b1000, 4'b0000, "div_blocked_t6");
    check("div_busy_t6", {3'b000, div_busy}, 4'b0001);
    cyc_chk(4'b1000, 4'b1000, "div_again_t7");
    check("cdb_div_t7", cdb_sel, 4'b1000);
    check("div_busy_t7", {3'b000, div_busy}, 4'b0000);

    // int/ls tie: int wins first after reset, ls next
    do_reset();
    cyc_chk(4'b0011, 4'b0001, "tie_int_first");
    cyc_chk(4'b0011, 4'b0010, "tie_ls_second");
    repeat (8) step(4'b0011);

    // reset in flight discards the mult result
    do_reset();
    cyc_chk(4'b0100, 4'b0100, "pre_rst_mult_t0");
    step(4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_cdb_t2", cdb_sel, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_cdb_t3", cdb_sel, 4'b0000);
    for (int k = 4; k <= 8; k++) begin
      step(4'b0000);
      @(negedge clk);
      check("post_rst_cdb", cdb_sel, 4'b0000);
      check("post_rst_busy", {3'b000, div_busy}, 4'b0000);
    end
    cyc_chk(4'b0011, 4'b0001, "post_rst_first_grant");

    // random traffic with rare resets
    for (int n = 0; n < 10000; n++) begin
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 99) < 55);
      @(posedge clk);
      #1;
      {div_ready, mult_ready, ls_ready, int_ready} = r;
      rst = ($urandom_range(0, 999) != 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    {div_ready, mult_ready, ls_ready, int_ready} = 4'b0000;
    repeat (MAX_LAT + 2) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
